// File: rtl/dedisp_sched.sv
// dedisp_sched: frame sequencer between the FFT channel stream and the serial
// dedispersor. It keeps the downstream channel counter aligned to spectrum
// boundaries by flushing with zero spectra, switching sources only at frame
// boundaries, and zero-padding frames broken by a misplaced sync.
// Optional feature: define DEDISP_SCHED_TEST_SRC_EN to compile in the
// test-source path; without it tst_* and src_sel are ignored.
module dedisp_sched #(
    parameter int N_CHANNELS   = 8,
    parameter int DIN_WIDTH    = 32,
    parameter int FLUSH_FRAMES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIN_WIDTH-1:0] fft_din,
    input  logic                 fft_valid,
    input  logic                 fft_sync,
    input  logic [DIN_WIDTH-1:0] tst_din,
    input  logic                 tst_valid,
    input  logic                 tst_sync,
    input  logic                 src_sel,
    input  logic                 flush_req,
    output logic [DIN_WIDTH-1:0] dout,
    output logic                 dout_valid,
    output logic                 dout_sof,
    output logic                 dout_eof,
    output logic                 src_active,
    output logic                 flushing,
    output logic                 sync_err,
    output logic [31:0]          frame_cnt
);
    localparam int CW = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
    localparam int FW = (FLUSH_FRAMES > 1) ? $clog2(FLUSH_FRAMES) : 1;
    localparam logic [CW-1:0] CH_LAST = CW'(N_CHANNELS - 1);
    localparam logic [FW-1:0] FR_LAST = FW'(FLUSH_FRAMES - 1);

    typedef enum logic [1:0] {S_FLUSH, S_IDLE, S_RUN, S_PAD} state_t;

    state_t                 state_q;
    logic [CW-1:0]          ch_cnt_q;
    logic [FW-1:0]          flush_frm_q;
    logic                   flush_pend_q;
    logic [DIN_WIDTH-1:0]   dout_q;
    logic                   dout_valid_q;
    logic                   dout_sof_q;
    logic                   dout_eof_q;
    logic                   src_active_q;
    logic                   flushing_q;
    logic                   sync_err_q;
    logic [31:0]            frame_cnt_q;

    // Requested source as seen by the switch logic; constant live without the test path.
    logic src_next;
`ifdef DEDISP_SCHED_TEST_SRC_EN
    assign src_next = src_sel;
`else
    assign src_next = 1'b0;
    logic unused_src_sel;
    assign unused_src_sel = src_sel;
`endif

    logic                 sel_d;
    logic                 in_valid_d;
    logic                 in_sync_d;
    logic [DIN_WIDTH-1:0] in_data_d;
    logic                 flush_pend_d;

    // Input mux: while idle the request picks the source directly so a sync on
    // the newly requested stream is caught without a dead cycle.
    always_comb begin
        sel_d        = (state_q == S_IDLE) ? src_next : src_active_q;
        in_valid_d   = sel_d ? tst_valid : fft_valid;
        in_sync_d    = sel_d ? tst_sync  : fft_sync;
        in_data_d    = sel_d ? tst_din   : fft_din;
        flush_pend_d = flush_pend_q | flush_req;
    end

    // Sequencer FSM with registered outputs; every emitted word advances ch_cnt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_FLUSH;
            ch_cnt_q     <= '0;
            flush_frm_q  <= '0;
            flush_pend_q <= 1'b0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_sof_q   <= 1'b0;
            dout_eof_q   <= 1'b0;
            src_active_q <= 1'b0;
            flushing_q   <= 1'b1;
            sync_err_q   <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_sof_q   <= 1'b0;
            dout_eof_q   <= 1'b0;
            sync_err_q   <= 1'b0;
            case (state_q)
                S_FLUSH: begin
                    // Requests arriving here are absorbed by the flush in progress.
                    dout_valid_q <= 1'b1;
                    dout_sof_q   <= (ch_cnt_q == '0);
                    dout_eof_q   <= (ch_cnt_q == CH_LAST);
                    ch_cnt_q     <= ch_cnt_q + CW'(1);
                    if (ch_cnt_q == CH_LAST) begin
                        if (flush_frm_q == FR_LAST) begin
                            flush_frm_q  <= '0;
                            flush_pend_q <= 1'b0;
                            flushing_q   <= 1'b0;
                            src_active_q <= src_next;
                            state_q      <= S_IDLE;
                        end else begin
                            flush_frm_q <= flush_frm_q + FW'(1);
                        end
                    end
                end
                S_IDLE: begin
                    src_active_q <= src_next;
                    flush_pend_q <= flush_pend_d;
                    if (flush_pend_d) begin
                        flushing_q <= 1'b1;
                        state_q    <= S_FLUSH;
                    end else if (in_valid_d && in_sync_d) begin
                        dout_q       <= in_data_d;
                        dout_valid_q <= 1'b1;
                        dout_sof_q   <= 1'b1;
                        ch_cnt_q     <= CW'(1);
                        state_q      <= S_RUN;
                    end
                end
                S_RUN: begin
                    flush_pend_q <= flush_pend_d;
                    if (in_valid_d) begin
                        if (in_sync_d && (ch_cnt_q != '0)) begin
                            sync_err_q <= 1'b1;
                            state_q    <= S_PAD;
                        end else begin
                            dout_q       <= in_data_d;
                            dout_valid_q <= 1'b1;
                            dout_sof_q   <= (ch_cnt_q == '0);
                            dout_eof_q   <= (ch_cnt_q == CH_LAST);
                            ch_cnt_q     <= ch_cnt_q + CW'(1);
                            if (ch_cnt_q == CH_LAST) begin
                                frame_cnt_q <= frame_cnt_q + 32'd1;
                                if (flush_pend_d) begin
                                    flushing_q <= 1'b1;
                                    state_q    <= S_FLUSH;
                                end else if (src_next != src_active_q) begin
                                    src_active_q <= src_next;
                                    state_q      <= S_IDLE;
                                end
                            end
                        end
                    end
                end
                default: begin // S_PAD
                    flush_pend_q <= flush_pend_d;
                    dout_valid_q <= 1'b1;
                    dout_sof_q   <= (ch_cnt_q == '0);
                    dout_eof_q   <= (ch_cnt_q == CH_LAST);
                    ch_cnt_q     <= ch_cnt_q + CW'(1);
                    if (ch_cnt_q == CH_LAST) begin
                        if (flush_pend_d) begin
                            flushing_q <= 1'b1;
                            state_q    <= S_FLUSH;
                        end else begin
                            src_active_q <= src_next;
                            state_q      <= S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_sof   = dout_sof_q;
    assign dout_eof   = dout_eof_q;
    assign src_active = src_active_q;
    assign flushing   = flushing_q;
    assign sync_err   = sync_err_q;
    assign frame_cnt  = frame_cnt_q;
endmodule

// File: tb/tb_dedisp_sched.sv
// tb_dedisp_sched: directed bench for dedisp_sched (N_CHANNELS=8, FLUSH_FRAMES=2)
// with a cycle-level reference model and hand-computed literal expectations.
module tb_dedisp_sched;
    localparam int N  = 8;
    localparam int FF = 2;
`ifdef DEDISP_SCHED_TEST_SRC_EN
    localparam bit TST_EN = 1'b1;
`else
    localparam bit TST_EN = 1'b0;
`endif
    localparam int M_FLUSH = 0, M_IDLE = 1, M_RUN = 2, M_PAD = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] fft_din = '0, tst_din = '0;
    logic        fft_valid = 1'b0, fft_sync = 1'b0;
    logic        tst_valid = 1'b0, tst_sync = 1'b0;
    logic        src_sel = 1'b0, flush_req = 1'b0;
    logic [31:0] dout, frame_cnt;
    logic        dout_valid, dout_sof, dout_eof, src_active, flushing, sync_err;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    dedisp_sched #(.N_CHANNELS(N), .DIN_WIDTH(32), .FLUSH_FRAMES(FF)) dut (
        .clk(clk), .rst(rst),
        .fft_din(fft_din), .fft_valid(fft_valid), .fft_sync(fft_sync),
        .tst_din(tst_din), .tst_valid(tst_valid), .tst_sync(tst_sync),
        .src_sel(src_sel), .flush_req(flush_req),
        .dout(dout), .dout_valid(dout_valid), .dout_sof(dout_sof), .dout_eof(dout_eof),
        .src_active(src_active), .flushing(flushing), .sync_err(sync_err),
        .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: mode, position within the spectrum, words left in a flush.
    int          m_mode, m_pos, m_left, m_frames;
    bit          m_pend, m_src;
    bit          e_valid, e_sof, e_eof, e_err;
    logic [31:0] e_data;

    task automatic emit(input logic [31:0] d);
        e_valid = 1'b1;
        e_data  = d;
        e_sof   = (m_pos == 0);
        e_eof   = (m_pos == N - 1);
        m_pos   = (m_pos + 1) % N;
    endtask

    always @(posedge clk or posedge rst) begin
        bit pend_now, want, src, v, s;
        logic [31:0] d;
        if (rst) begin
            m_mode = M_FLUSH; m_pos = 0; m_left = N * FF; m_pend = 0; m_src = 0;
            m_frames = 0; e_valid = 0; e_sof = 0; e_eof = 0; e_err = 0; e_data = '0;
        end else begin
            e_valid = 0; e_sof = 0; e_eof = 0; e_err = 0; e_data = '0;
            pend_now = m_pend | flush_req;
            want = TST_EN ? src_sel : 1'b0;
            src  = (m_mode == M_IDLE) ? want : m_src;
            v = src ? tst_valid : fft_valid;
            s = src ? tst_sync : fft_sync;
            d = src ? tst_din : fft_din;
            case (m_mode)
                M_FLUSH: begin
                    emit('0);
                    m_left--;
                    if (m_left == 0) begin m_mode = M_IDLE; m_pend = 0; m_src = want; end
                end
                M_IDLE: begin
                    m_src = want;
                    m_pend = pend_now;
                    if (pend_now) begin m_mode = M_FLUSH; m_left = N * FF; end
                    else if (v && s) begin emit(d); m_mode = M_RUN; end
                end
                M_RUN: begin
                    m_pend = pend_now;
                    if (v) begin
                        if (s && m_pos != 0) begin e_err = 1; m_mode = M_PAD; end
                        else begin
                            emit(d);
                            if (m_pos == 0) begin
                                m_frames++;
                                if (pend_now) begin m_mode = M_FLUSH; m_left = N * FF; end
                                else if (want != m_src) begin m_mode = M_IDLE; m_src = want; end
                            end
                        end
                    end
                end
                default: begin
                    m_pend = pend_now;
                    emit('0);
                    if (m_pos == 0) begin
                        if (pend_now) begin m_mode = M_FLUSH; m_left = N * FF; end
                        else begin m_mode = M_IDLE; m_src = want; end
                    end
                end
            endcase
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        bit bad;
        if (cmp_en) begin
            bad = (dout_valid !== e_valid) || (dout_sof !== e_sof) || (dout_eof !== e_eof) ||
                  (e_valid && (dout !== e_data)) || (sync_err !== e_err) ||
                  (flushing !== (m_mode == M_FLUSH)) || (src_active !== m_src) ||
                  (frame_cnt !== 32'(m_frames));
            n_vec++;
            if (bad) begin
                n_err++;
                $display("FAIL cycle_model t=%0t got v=%b d=%0h sof=%b eof=%b err=%b fl=%b src=%b fc=%0d required v=%b d=%0h sof=%b eof=%b err=%b fl=%b src=%b fc=%0d",
                         $time, dout_valid, dout, dout_sof, dout_eof, sync_err, flushing, src_active, frame_cnt,
                         e_valid, e_data, e_sof, e_eof, e_err, (m_mode == M_FLUSH), m_src, m_frames);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One cycle of stimulus on both streams, then return inputs to quiet.
    task automatic drive(input bit fv, input logic [31:0] fd, input bit fs,
                         input bit tv, input logic [31:0] td, input bit ts, input bit fr);
        fft_valid = fv; fft_din = fd; fft_sync = fs;
        tst_valid = tv; tst_din = td; tst_sync = ts; flush_req = fr;
        tick();
        fft_valid = 0; fft_sync = 0; tst_valid = 0; tst_sync = 0; flush_req = 0;
    endtask

    task automatic live(input logic [31:0] d, input bit s, input bit fr);
        drive(1'b1, d, s, 1'b0, '0, 1'b0, fr);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        #1 rst = 1'b1;
        cmp_en = 1'b1;
        repeat (3) tick();
        check("reset_valid", 32'(dout_valid), 0);
        check("reset_flushing", 32'(flushing), 1);
        check("reset_frame_cnt", frame_cnt, 0);
        check("reset_src_active", 32'(src_active), 0);

        // Power-up flush: 16 zero words.
        rst = 1'b0;
        for (int k = 0; k < N * FF; k++) begin
            idle(1);
            check("flush0_valid", 32'(dout_valid), 1);
            check("flush0_data", dout, 0);
            check("flush0_sof", 32'(dout_sof), 32'(k % N == 0));
            check("flush0_eof", 32'(dout_eof), 32'(k % N == N - 1));
        end
        idle(1);
        check("flush0_done_valid", 32'(dout_valid), 0);
        check("flush0_done_flushing", 32'(flushing), 0);
        check("flush0_done_fc", frame_cnt, 0);

        // Live frame 1..8, continuous.
        for (int c = 0; c < N; c++) begin
            live(32'(c + 1), c == 0, 1'b0);
            check("frame1_data", dout, 32'(c + 1));
            check("frame1_sof", 32'(dout_sof), 32'(c == 0));
            check("frame1_eof", 32'(dout_eof), 32'(c == N - 1));
        end
        check("frame1_fc", frame_cnt, 1);

        // Same shape with random input gaps.
        for (int c = 0; c < N; c++) begin
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
            live(32'(11 + c), c == 0, 1'b0);
        end
        check("gap_last_data", dout, 18);
        check("gap_fc", frame_cnt, 2);

        // Two back-to-back frames.
        for (int c = 0; c < 2 * N; c++) live(32'(31 + c), (c % N) == 0, 1'b0);
        check("b2b_fc", frame_cnt, 4);

        // Source switch requested mid-frame; test stream chatters meanwhile.
        for (int c = 0; c < N; c++) begin
            if (c == 3) src_sel = 1'b1;
            drive(1'b1, 32'(21 + c), 1'b0 || (c == 0), 1'b1, 32'(900 + c), c == 0, 1'b0);
        end
        check("switch_src_active", 32'(src_active), 32'(TST_EN));
        for (int c = 0; c < N; c++) begin
            if (c == 4) src_sel = 1'b0;
            drive(1'b1, 32'(201 + c), c == 0, 1'b1, 32'(101 + c), c == 0, 1'b0);
            if (c == 0) check("switch_first_word", dout, TST_EN ? 32'd101 : 32'd201);
        end
        for (int c = 0; c < N; c++) live(32'(61 + c), c == 0, 1'b0);
        check("switch_back_data", dout, 68);
        check("switch_fc", frame_cnt, 7);

        // Sync error at channel 5: three pad words, frame not counted.
        for (int c = 0; c < 5; c++) live(32'(50 + c), c == 0, 1'b0);
        live(32'd55, 1'b1, 1'b0);
        check("syncerr_pulse", 32'(sync_err), 1);
        check("syncerr_valid", 32'(dout_valid), 0);
        for (int p = 0; p < 3; p++) begin
            live(32'hDEAD, 1'b0, 1'b0);
            check("pad_valid", 32'(dout_valid), 1);
            check("pad_data", dout, 0);
            check("pad_eof", 32'(dout_eof), 32'(p == 2));
        end
        check("pad_fc", frame_cnt, 7);
        idle(2);
        for (int c = 0; c < N; c++) begin
            live(32'(71 + c), c == 0, 1'b0);
            if (c == 0) check("after_pad_sof", 32'(dout_sof), 1);
        end
        check("after_pad_fc", frame_cnt, 8);

        // Flush requested mid-frame: frame completes, then 16 zero words.
        for (int c = 0; c < N; c++) live(32'(81 + c), c == 0, c == 2);
        check("flushreq_fc", frame_cnt, 9);
        for (int k = 0; k < N * FF; k++) begin
            live(32'hBEEF, 1'b0, 1'b0);
            check("flush1_valid", 32'(dout_valid), 1);
            check("flush1_data", dout, 0);
        end
        live(32'hBEEF, 1'b0, 1'b0);
        check("flush1_done_valid", 32'(dout_valid), 0);

        // Flush request on the eof cycle; a second request inside the flush is absorbed.
        for (int c = 0; c < N; c++) live(32'(91 + c), c == 0, c == N - 1);
        live(32'hBEEF, 1'b0, 1'b1);
        check("flush2_first_valid", 32'(dout_valid), 1);
        check("flush2_first_sof", 32'(dout_sof), 1);
        check("flush2_flushing", 32'(flushing), 1);
        idle(N * FF - 1);
        idle(1);
        check("flush2_done_valid", 32'(dout_valid), 0);
        check("flush2_done_flushing", 32'(flushing), 0);
        check("flush2_fc", frame_cnt, 10);

        // Reset mid-frame clears outputs immediately; a full flush follows release.
        for (int c = 0; c < 3; c++) live(32'(101 + c), c == 0, 1'b0);
        rst = 1'b1;
        #1;
        check("rst_async_valid", 32'(dout_valid), 0);
        check("rst_async_data", dout, 0);
        check("rst_async_fc", frame_cnt, 0);
        check("rst_async_flushing", 32'(flushing), 1);
        idle(2);
        rst = 1'b0;
        for (int k = 0; k < N * FF; k++) begin
            idle(1);
            check("flush3_valid", 32'(dout_valid), 1);
            check("flush3_sof", 32'(dout_sof), 32'(k % N == 0));
        end
        idle(1);
        check("flush3_done_valid", 32'(dout_valid), 0);
        for (int c = 0; c < N; c++) live(32'(111 + c), c == 0, 1'b0);
        check("final_fc", frame_cnt, 1);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
